serv_bufreg_sched: RTL
======================

# serv_bufreg_sched

Bit-serial pass scheduler that shares the single address/buffer register between the SERV core and the VPU. It arbitrates pass requests and owns the bit counter. It drives the register's per-bit strobes (first bit, second bit, enable, init, clear-LSB, VPU-ownership) for exactly WIDTH enabled cycles per pass. It signals completion to the requester that won the pass. It sits between the core/VPU control logic and the buffer register, replacing the ad-hoc strobe generation in each requester.

## Interface
Parameters:
- WIDTH, 32, bits per pass; power of two, 4..64.
- VPU, 1, 0 ties VPU requester off (o_vpu_gnt/o_vpu_done held 0, core always wins).

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_core_req  in  1  core requests a pass; held until o_core_gnt.
- i_core_init  in  1  pass is an init (load/add) pass; sampled at grant.
- i_core_clr_lsb  in  1  clear LSB on first bit; sampled at grant.
- o_core_gnt  out  1  one-cycle accept pulse.
- o_core_done  out  1  one-cycle pulse after core pass completes.
- i_vpu_req, i_vpu_init, i_vpu_clr_lsb, o_vpu_gnt, o_vpu_done: same as the core set, for the VPU.
- i_stall  in  1  freeze current pass (no bit advances).
- o_en  out  1  bit enable to register.
- o_init  out  1  init strobe for current pass.
- o_clr_lsb  out  1  latched clear-LSB flag, valid while busy.
- o_cnt0, o_cnt1  out  1 each  first/second enabled bit of pass.
- o_vpu_op  out  1  current pass owned by VPU.
- o_cnt  out  $clog2(WIDTH)  bit index.
- o_busy  out  1  pass in progress.

## Operation
- States: IDLE, RUN. Reset -> IDLE.
- IDLE: if any request is valid, arbitrate combinationally. Assert the winner's gnt in the same cycle, latch owner/init/clr_lsb, clear cnt, and go to RUN next edge.
- Arbitration is round-robin on the last_owner register. Simultaneous requests: the requester that is not last_owner wins. last_owner resets to VPU, so the core wins the first tie. A single request always wins.
- RUN:
  - o_en = !i_stall.
  - cnt increments on each o_en cycle.
  - o_cnt0 = (cnt==0), o_cnt1 = (cnt==1), both gated with o_en.
  - o_init and o_vpu_op come from the latched values, held through the whole pass including stall cycles.
- A cycle with o_en and cnt==WIDTH-1 is the last bit. Next edge: state IDLE, owner's done register set. Done is a one-cycle pulse.
- Outside RUN, o_en/o_init/o_cnt0/o_cnt1/o_vpu_op/o_clr_lsb are 0. This guarantees the register's carry clears between passes.
- Request deassertion during RUN is ignored; the pass always completes.
- A request that is asserted and then dropped in IDLE before grant is lost.
- Stall during the last bit: that bit does not occur. Completion waits for the next unstalled cycle.

## Timing
- Reset values: state IDLE, cnt 0, last_owner VPU, all outputs 0.
- Grant to first bit: 1 cycle (gnt in cycle T, o_cnt0 in T+1 if not stalled).
- Unstalled pass: bits in T+1..T+WIDTH, done pulse in T+WIDTH+1.
- Done and the next gnt may coincide in the same cycle (IDLE is reached with done). Back-to-back pass period is WIDTH+1 cycles.
- Each stall cycle adds exactly one cycle of latency.
- Async reset mid-pass: immediate IDLE, all outputs 0, no done pulse. The interrupted requester must re-request.

## Structure
- Shared package holds:
  - the owner encoding (OWNER_CORE=0, OWNER_VPU=1);
  - the state enum (IDLE, RUN);
  - a function giving the counter width from WIDTH.
- Optional sub-module: serv_rr_arb2, a two-input round-robin arbiter with last_owner register. Everything else is a single module.

## Test plan
- Core only, init=1, WIDTH=32:
  - o_core_gnt at T;
  - o_cnt0 at T+1, o_cnt1 at T+2;
  - o_init high T+1..T+32;
  - o_core_done only at T+33; o_en low at T+33.
- Simultaneous core+VPU requests from reset:
  - core granted first, VPU granted in the core's done cycle;
  - o_vpu_op high for exactly 32 enabled cycles.
- Both requesting continuously: grants alternate core, VPU, core, VPU; no requester wins twice in a row.
- i_stall high for 3 cycles at cnt==5:
  - o_en low and cnt frozen at 5 for 3 cycles;
  - done arrives at T+36.
- Stall on the last bit (cnt==31): done is delayed until the cycle after the first unstalled enabled bit.
- i_rst_n asserted at cnt==10 of a VPU pass: all outputs 0 immediately, no o_vpu_done; after release, a core request is granted in 1 cycle.

Source files
------------

// File: rtl/serv_bufreg_sched_pkg.sv
// Shared types for the buffer-register pass scheduler: owner encoding,
// scheduler state and the bit-counter width helper.
package serv_bufreg_sched_pkg;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_VPU  = 1'b1
    } owner_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width of the bit index for a pass of w bits (w is a power of two).
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serv_rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// last time is chosen; a lone request always wins. last_owner resets to
// the VPU so the core takes the first tie.
module serv_rr_arb2
    import serv_bufreg_sched_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_req_core,
    input  logic   i_req_vpu,
    input  logic   i_accept,
    output logic   o_gnt_core,
    output logic   o_gnt_vpu,
    output owner_e o_winner
);

    owner_e last_owner;

    // Pick the winner from the current requests and the previous owner
    always_comb begin
        o_winner = OWNER_CORE;
        if (i_req_core && i_req_vpu)
            o_winner = (last_owner == OWNER_VPU) ? OWNER_CORE : OWNER_VPU;
        else if (i_req_vpu)
            o_winner = OWNER_VPU;
    end

    assign o_gnt_core = i_accept && i_req_core && (o_winner == OWNER_CORE);
    assign o_gnt_vpu  = i_accept && i_req_vpu  && (o_winner == OWNER_VPU);

    // Remember who won the last accepted pass
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_owner <= OWNER_VPU;
        else if (o_gnt_core || o_gnt_vpu)
            last_owner <= o_winner;
    end

endmodule

// File: rtl/serv_bufreg_sched.sv
// Bit-serial pass scheduler sharing the buffer register between the core
// and the VPU. Grants a pass, then strobes the register for exactly WIDTH
// enabled cycles and pulses done to the pass owner.
module serv_bufreg_sched
    import serv_bufreg_sched_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int VPU   = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_core_req,
    input  logic                          i_core_init,
    input  logic                          i_core_clr_lsb,
    output logic                          o_core_gnt,
    output logic                          o_core_done,
    input  logic                          i_vpu_req,
    input  logic                          i_vpu_init,
    input  logic                          i_vpu_clr_lsb,
    output logic                          o_vpu_gnt,
    output logic                          o_vpu_done,
    input  logic                          i_stall,
    output logic                          o_en,
    output logic                          o_init,
    output logic                          o_clr_lsb,
    output logic                          o_cnt0,
    output logic                          o_cnt1,
    output logic                          o_vpu_op,
    output logic [cnt_width(WIDTH)-1:0]   o_cnt,
    output logic                          o_busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e        state;
    logic [CW-1:0] cnt;
    owner_e        owner;
    logic          init_q;
    logic          clr_q;
    logic          core_done_q;
    logic          vpu_done_q;

    logic   run;
    logic   vpu_req_eff;
    logic   gnt_core;
    logic   gnt_vpu;
    owner_e winner;
    logic   last_bit;

    assign run         = (state == RUN);
    // With VPU=0 the VPU side never requests, so the core always wins
    assign vpu_req_eff = (VPU != 0) && i_vpu_req;

    serv_rr_arb2 u_arb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req_core (i_core_req),
        .i_req_vpu  (vpu_req_eff),
        .i_accept   (!run),
        .o_gnt_core (gnt_core),
        .o_gnt_vpu  (gnt_vpu),
        .o_winner   (winner)
    );

    // Strobes are forced low outside RUN so the register's carry clears
    assign o_en      = run && !i_stall;
    assign o_init    = run && init_q;
    assign o_clr_lsb = run && clr_q;
    assign o_vpu_op  = run && (owner == OWNER_VPU);
    assign o_cnt0    = o_en && (cnt == '0);
    assign o_cnt1    = o_en && (cnt == CW'(1));
    assign o_cnt     = cnt;
    assign o_busy    = run;

    assign o_core_gnt  = gnt_core;
    assign o_vpu_gnt   = gnt_vpu;
    assign o_core_done = core_done_q;
    assign o_vpu_done  = vpu_done_q;

    // A stalled last bit does not count; completion waits for it
    assign last_bit = o_en && (cnt == LAST);

    // Pass FSM: latch pass attributes on grant, count bits, pulse done
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= OWNER_CORE;
            init_q      <= 1'b0;
            clr_q       <= 1'b0;
            core_done_q <= 1'b0;
            vpu_done_q  <= 1'b0;
        end else begin
            core_done_q <= 1'b0;
            vpu_done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_core || gnt_vpu) begin
                        state  <= RUN;
                        owner  <= winner;
                        cnt    <= '0;
                        init_q <= (winner == OWNER_VPU) ? i_vpu_init    : i_core_init;
                        clr_q  <= (winner == OWNER_VPU) ? i_vpu_clr_lsb : i_core_clr_lsb;
                    end
                end
                RUN: begin
                    if (o_en)
                        cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        state       <= IDLE;
                        core_done_q <= (owner == OWNER_CORE);
                        vpu_done_q  <= (owner == OWNER_VPU);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
